switch_debounce_2: RTL and testbench



---
 rtl/switch_debounce_2.sv | 93 +++++++++
 tb/tb_switch_debounce_2.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_2.sv
// Two-channel switch conditioner: 2-flop synchronizer, per-channel stability counter,
// debounced levels with one-cycle rise/fall pulses and a combined settled flag.
module switch_debounce_2 #(
    parameter int CNT_MAX = 1000000,
    parameter int CNT_W   = 20
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iSwA,
    input  logic iSwB,
    output logic oA,
    output logic oB,
    output logic oA_rise,
    output logic oA_fall,
    output logic oB_rise,
    output logic oB_fall,
    output logic oStable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    // Channel index 0 is A, index 1 is B.
    logic [1:0]            swRaw_s;
    logic [1:0]            sync1_r;
    logic [1:0]            sync2_r;
    logic [1:0]            level_r;
    logic [1:0]            rise_r;
    logic [1:0]            fall_r;
    logic [1:0][CNT_W-1:0] cnt_r;
    logic                  stable_r;
    logic [1:0]            mismatch_s;
    logic [1:0]            flip_s;

    assign swRaw_s = {iSwB, iSwA};

    // Per-channel mismatch and flip decisions from pre-edge state.
    always_comb begin
        mismatch_s = 2'b00;
        flip_s     = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (sync2_r[i] != level_r[i]) begin
                mismatch_s[i] = 1'b1;
                flip_s[i]     = (cnt_r[i] == CNT_LAST);
            end else begin
                mismatch_s[i] = 1'b0;
                flip_s[i]     = 1'b0;
            end
        end
    end

    // Synchronizers, stability counters, debounced levels, pulses and settled flag.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            sync1_r  <= 2'b00;
            sync2_r  <= 2'b00;
            level_r  <= 2'b00;
            rise_r   <= 2'b00;
            fall_r   <= 2'b00;
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else begin
            sync1_r <= swRaw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 2; i++) begin
                if (!mismatch_s[i]) begin
                    // Any return to the current level discards the partial count.
                    cnt_r[i]  <= '0;
                    rise_r[i] <= 1'b0;
                    fall_r[i] <= 1'b0;
                end else if (flip_s[i]) begin
                    level_r[i] <= sync2_r[i];
                    cnt_r[i]   <= '0;
                    rise_r[i]  <= sync2_r[i];
                    fall_r[i]  <= ~sync2_r[i];
                end else begin
                    cnt_r[i]  <= cnt_r[i] + CNT_W'(1);
                    rise_r[i] <= 1'b0;
                    fall_r[i] <= 1'b0;
                end
            end
            stable_r <= (cnt_r == '0) && (mismatch_s == 2'b00);
        end
    end

    assign oA      = level_r[0];
    assign oB      = level_r[1];
    assign oA_rise = rise_r[0];
    assign oA_fall = fall_r[0];
    assign oB_rise = rise_r[1];
    assign oB_fall = fall_r[1];
    assign oStable = stable_r;

endmodule

// File: tb/tb_switch_debounce_2.sv
// Directed bench for switch_debounce_2 with CNT_MAX=4; expected values hand-derived per edge.
module tb_switch_debounce_2;

    logic iClk = 1'b0;
    logic iRst_n;
    logic iSwA;
    logic iSwB;
    logic oA, oB, oA_rise, oA_fall, oB_rise, oB_fall, oStable;
    logic [6:0] obs;
    int total = 0;
    int bad   = 0;

    switch_debounce_2 #(.CNT_MAX(4), .CNT_W(4)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iSwA   (iSwA),
        .iSwB   (iSwB),
        .oA     (oA),
        .oB     (oB),
        .oA_rise(oA_rise),
        .oA_fall(oA_fall),
        .oB_rise(oB_rise),
        .oB_fall(oB_fall),
        .oStable(oStable)
    );

    always #5 iClk = ~iClk;

    // {oA, oB, oA_rise, oA_fall, oB_rise, oB_fall, oStable}
    assign obs = {oA, oB, oA_rise, oA_fall, oB_rise, oB_fall, oStable};

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    // Reset with both switches high, then release: both channels rise together.
    task automatic test_reset();
        logic [6:0] exp;
        logic lv, p, st;
        iRst_n = 1'b0;
        iSwA = 1'b1;
        iSwB = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            total++;
            if (obs !== 7'b0000000) begin
                bad++;
                $display("FAIL reset k=%0d got=%b want=%b", k, obs, 7'b0000000);
            end
        end
        iRst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            lv  = (k >= 5);
            p   = (k == 5);
            st  = (k <= 1) || (k >= 6);
            exp = {lv, lv, p, 1'b0, p, 1'b0, st};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_release k=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    // Both switches drop on the same cycle: both channels fall in the same cycle.
    task automatic test_both_fall();
        logic [6:0] exp;
        logic lv, p, st;
        iSwA = 1'b0;
        iSwB = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            lv  = (k < 5);
            p   = (k == 5);
            st  = (k <= 1) || (k >= 6);
            exp = {lv, lv, 1'b0, p, 1'b0, p, st};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL both_fall k=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    // Clean press on A; B stays quiet.
    task automatic test_clean_press();
        logic [6:0] exp;
        logic lv, p, st;
        iSwA = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            lv  = (k >= 5);
            p   = (k == 5);
            st  = (k <= 1) || (k >= 6);
            exp = {lv, 1'b0, p, 1'b0, 1'b0, 1'b0, st};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL clean_press k=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    // B high for 3 cycles reaches CNT_MAX-1 but must not flip.
    task automatic test_glitch();
        logic [6:0] exp;
        logic st;
        for (int k = 0; k < 9; k++) begin
            iSwB = (k < 3);
            cyc();
            st  = (k <= 1) || (k >= 6);
            exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, st};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL glitch k=%0d got=%b want=%b", k, obs, exp);
            end
        end
        iSwB = 1'b0;
    endtask

    // A released with oA=1: single fall pulse, no rise.
    task automatic test_release();
        logic [6:0] exp;
        logic lv, p, st;
        iSwA = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            lv  = (k < 5);
            p   = (k == 5);
            st  = (k <= 1) || (k >= 6);
            exp = {lv, 1'b0, 1'b0, p, 1'b0, 1'b0, st};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL release k=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    // Reset on edge 3 of an A press discards the count; full latency after release.
    task automatic test_reset_midcount();
        logic [6:0] exp;
        logic lv, p, st;
        iSwA = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            st  = (k <= 1);
            exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, st};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL midcount_pre k=%0d got=%b want=%b", k, obs, exp);
            end
        end
        iRst_n = 1'b0;
        cyc();
        total++;
        if (obs !== 7'b0000000) begin
            bad++;
            $display("FAIL midcount_rst got=%b want=%b", obs, 7'b0000000);
        end
        iRst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            lv  = (k >= 5);
            p   = (k == 5);
            st  = (k <= 1) || (k >= 6);
            exp = {lv, 1'b0, p, 1'b0, 1'b0, 1'b0, st};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL midcount_post k=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    // A bounces 1,0,1,0 then holds 1: one rise once the final level has persisted.
    task automatic test_bounce();
        logic [6:0] exp;
        logic lv, p, st;
        for (int k = 0; k < 12; k++) begin
            if (k < 4) iSwA = (k % 2 == 0);
            else       iSwA = 1'b1;
            cyc();
            lv  = (k >= 9);
            p   = (k == 9);
            st  = (k <= 1) || (k >= 10);
            exp = {lv, 1'b0, p, 1'b0, 1'b0, 1'b0, st};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL bounce k=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_both_fall();
        test_clean_press();
        test_glitch();
        test_release();
        test_reset_midcount();
        test_release();
        test_bounce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
